// File: rtl/axis_flit_reassembler.sv
// Receive endpoint for the NoC flit/credit interface. Flits land in a small
// credit-managed FIFO, are packed SERIALIZATION_FACTOR at a time into one
// AXI-Stream beat, and every flit drained from the FIFO returns one credit.
module axis_flit_reassembler #(
  parameter int DEST_WIDTH           = 6,
  parameter int TDATA_WIDTH          = 512,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int FLIT_BUFFER_DEPTH    = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0] data_in,
  input  logic [DEST_WIDTH-1:0]                       dest_in,
  input  logic                                        is_tail_in,
  input  logic                                        send_in,
  output logic                                        credit_out,
  output logic                                        axis_tvalid,
  input  logic                                        axis_tready,
  output logic [TDATA_WIDTH-1:0]                      axis_tdata,
  output logic                                        axis_tlast,
  output logic [DEST_WIDTH-1:0]                       axis_tdest,
  output logic                                        overflow_err
);

  localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
  localparam int SLICE_W    = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam int PTR_W      = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int OCC_W      = $clog2(FLIT_BUFFER_DEPTH + 1);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  tail;
  } flit_t;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  // FIFO storage and pointers
  flit_t              mem_q [FLIT_BUFFER_DEPTH];
  flit_t              mem_d [FLIT_BUFFER_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               overflow_q, overflow_d;
  logic               credit_q, credit_d;

  // Beat assembly
  state_t             state_q, state_d;
  logic [SLICE_W-1:0] cnt_q, cnt_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic               tlast_q, tlast_d;
  logic [DEST_WIDTH-1:0] tdest_q, tdest_d;

  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic [SLICE_W-1:0] slice_idx;
  flit_t              head;

  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == OCC_W'(FLIT_BUFFER_DEPTH));
  assign head       = mem_q[rd_ptr_q];

  // Assembly FSM: decides when to pop and where the popped flit lands.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    tdest_d   = tdest_q;
    pop       = 1'b0;
    slice_idx = cnt_q;
    case (state_q)
      COLLECT: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          slice_idx = cnt_q;
        end
      end
      HOLD: begin
        if (axis_tready) begin
          if (!fifo_empty) begin
            // Beat accepted and the next flit is already waiting: start the
            // next beat in the same cycle so back-to-back beats lose no cycle.
            pop       = 1'b1;
            slice_idx = '0;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      default: state_d = COLLECT;
    endcase

    if (pop) begin
      if (slice_idx == '0) begin
        // First flit of a beat clears stale upper slices left by a short packet.
        tdata_d = '0;
        tdest_d = head.dest;
        tlast_d = 1'b0;
      end
      for (int k = 0; k < SERIALIZATION_FACTOR; k++) begin
        if (slice_idx == SLICE_W'(k)) tdata_d[k*FLIT_WIDTH +: FLIT_WIDTH] = head.data;
      end
      if ((slice_idx == SLICE_W'(SERIALIZATION_FACTOR - 1)) || head.tail) begin
        tlast_d = head.tail;
        cnt_d   = '0;
        state_d = HOLD;
      end else begin
        cnt_d   = slice_idx + 1'b1;
        state_d = COLLECT;
      end
    end
  end

  // Flit FIFO bookkeeping: push/pop, occupancy, overflow and credit return.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    // A push into a full FIFO still fits if the head leaves in the same cycle.
    push       = send_in && (!fifo_full || pop);
    overflow_d = overflow_q || (send_in && fifo_full && !pop);
    credit_d   = pop;

    if (push) begin
      mem_d[wr_ptr_q] = '{data: data_in, dest: dest_in, tail: is_tail_in};
      wr_ptr_d = (wr_ptr_q == PTR_W'(FLIT_BUFFER_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FLIT_BUFFER_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (!push && pop) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // FIFO payload storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
      credit_q   <= 1'b0;
      state_q    <= COLLECT;
      cnt_q      <= '0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tdest_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
      credit_q   <= credit_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      tdest_q    <= tdest_d;
    end
  end

  assign axis_tvalid  = (state_q == HOLD);
  assign axis_tdata   = tdata_q;
  assign axis_tlast   = tlast_q;
  assign axis_tdest   = tdest_q;
  assign credit_out   = credit_q;
  assign overflow_err = overflow_q;

endmodule

// File: doc/axis_flit_reassembler.md
Name: axis_flit_reassembler

Overview:
Single-clock receive endpoint for the NoC flit/credit interface: data, dest, is_tail, send and credit.
- Accepts flits from a router output port into a credit-managed flit buffer.
- Reassembles SERIALIZATION_FACTOR flits into one AXI-Stream beat.
- Returns one credit per flit consumed.
- Used where the user logic runs on the NoC clock, so no CDC shim is needed. It is the receiving counterpart of the flit transmit path.

Parameters:
DEST_WIDTH, 6, width of dest_in and axis_tdest (TDEST plus TID bits).
TDATA_WIDTH, 512, AXIS data width; must be divisible by SERIALIZATION_FACTOR.
SERIALIZATION_FACTOR, 4, flits per AXIS beat (>=1).
FLIT_BUFFER_DEPTH, 4, flit FIFO entries; equals the credits upstream holds after reset.
Derived: FLIT_WIDTH = TDATA_WIDTH/SERIALIZATION_FACTOR.

Ports:
clk  in  1  clock; every flop is in this domain.
rst_n  in  1  synchronous, active-low reset.
data_in  in  FLIT_WIDTH  flit payload.
dest_in  in  DEST_WIDTH  flit destination/ID.
is_tail_in  in  1  flit is last of its packet.
send_in  in  1  flit valid; one flit per cycle, no ready.
credit_out  out  1  one-cycle pulse per flit freed from the buffer.
axis_tvalid  out  1  beat valid.
axis_tready  in  1  downstream ready.
axis_tdata  out  TDATA_WIDTH  reassembled beat; flit k occupies bits [k*FLIT_WIDTH +: FLIT_WIDTH].
axis_tlast  out  1  is_tail of the beat's final flit.
axis_tdest  out  DEST_WIDTH  dest_in of the beat's flit 0.
overflow_err  out  1  sticky: a flit arrived with the FIFO full.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO emptied, slice counter cnt=0, state COLLECT.
  - All outputs 0: axis_tvalid, axis_tdata, axis_tlast, axis_tdest, credit_out, overflow_err.
  - Reset mid-beat discards partial beat and buffered flits; no credits are returned for them (upstream resets with the NoC).
- Flit FIFO:
  - Push on send_in; registered, no bypass, so a flit pushed in cycle t is poppable at t+1 at the earliest.
  - Push while full is dropped and sets overflow_err, except when a pop occurs in the same cycle; then the push is accepted.
  - credit_out=1 in the cycle after each pop (registered); continuous pops give continuous credit_out=1.
- State COLLECT (axis_tvalid=0):
  - If FIFO non-empty: pop, write slice[cnt]; if cnt==0 also latch tdest and zero all higher slices.
  - If cnt==SERIALIZATION_FACTOR-1 or is_tail: set tlast=is_tail, cnt=0, go HOLD.
  - Otherwise cnt++.
- State HOLD (axis_tvalid=1): tdata/tlast/tdest held stable until axis_tvalid&&axis_tready.
  - On handshake with FIFO non-empty: pop the next flit into slice 0 in the same cycle, same completion rule as COLLECT (stay HOLD if complete, else COLLECT with cnt=1).
  - On handshake with FIFO empty: go COLLECT.
  - No pop in HOLD without a handshake.
- Early tail (is_tail on flit k < SERIALIZATION_FACTOR-1): beat closes with slices k+1.. equal to 0 and tlast=1; the next flit starts a new beat at slice 0.
- dest_in on non-first flits is ignored.
- Timing:
  - Latency: last flit sent at cycle t gives axis_tvalid=1 at t+2.
  - Throughput with tready=1 and flits every cycle: one beat per SERIALIZATION_FACTOR cycles.

Test Plan:
1. SF=4, FLIT_WIDTH=128, tready=1; flits A0..A3 on consecutive cycles with dest=0x15 and tail on A3 -> axis_tvalid 2 cycles after A3, tdata={A3,A2,A1,A0}, tlast=1, tdest=0x15, four credit_out pulses.
2. tready=0; send 8 flits, each issued only when a credit is available (4 initial + returned) -> beat 1 held stable, 4 credits then none. Raise tready -> beat 1 accepted, beat 2 completes 4 cycles later, 4 more credits.
3. Tail on flit 1 (B0,B1) then C0..C3 -> beat 1 = {0,0,B1,B0}, tlast=1; beat 2 = {C3..C0}.
4. tready=0 with a full beat in HOLD and a full FIFO; send a 5th flit -> flit dropped, overflow_err=1 and stays 1 until rst_n=0.
5. After 2 flits collected, rst_n=0 for one cycle -> all outputs 0 at next edge; 4 new flits then produce a correct beat with no stale slices.
6. Continuous flits, tready=1, 16 flits -> 4 beats at 4-cycle spacing, credit_out high every cycle after the first pop.
